fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined CPU. Owns the PC and drives a synchronous-read instruction memory.
//  Feeds the IF/ID pipeline register consumed by the decode/register stage.
//  Supports decode stalls (no fetch lost or duplicated) and downstream branch redirects (wrong-path squash).
// PARAMETERS
//  ADDR_W     64             PC / instruction address width
//  INSTR_W    32             instruction width
//  RESET_PC   64'h0          first fetch address after reset
//  NOP_INSTR  32'hD503201F   instruction value driven on if_id_instr when the slot is empty
// PORTS
//  clk           in   1        single clock; all state updates on posedge
//  reset         in   1        asynchronous, active-low (0 = reset)
//  imem_req      out  1        fetch request; memory registers imem_addr on the edge when imem_req=1
//  imem_addr     out  ADDR_W   fetch address; meaningful only when imem_req=1
//  imem_rdata    in   INSTR_W  data for the request of the previous cycle
//  stall         in   1        decode cannot accept; hold IF/ID
//  redirect      in   1        branch taken, resolved downstream
//  redirect_pc   in   ADDR_W   branch target; bits [1:0] treated as 00
//  if_id_valid   out  1        IF/ID holds a live instruction
//  if_id_instr   out  INSTR_W  IF/ID instruction
//  if_id_pc      out  ADDR_W   address of if_id_instr
//  fetch_count   out  32       count of instructions loaded into IF/ID with valid=1; wraps mod 2^32
// BEHAVIOUR
//  Reset values:
//   - pc=RESET_PC, state=BOOT, imem_req=0.
//   - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, fetch_count=0.
//   - inflight and skid empty.
//  Internal state:
//   - inflight_v/inflight_pc: a request was issued last cycle.
//   - skid_v/skid_instr/skid_pc: one-entry hold buffer.
//  States BOOT, RUN, HOLD. Priority: reset > redirect > stall > normal.
//  redirect=1 (any state):
//   - imem_req=1 and imem_addr=redirect_pc&~3 combinationally in the same cycle.
//   - pc<=target+4. IF/ID valid<=0. inflight_pc<=target. skid cleared. state<=RUN.
//   - Target instruction is in IF/ID with valid=1 two edges later.
//  BOOT, no stall:
//   - imem_req=1 at pc, pc+=4, state<=RUN.
//   - IF/ID stays invalid.
//  BOOT, stall: no request; hold.
//  RUN, no stall:
//   - imem_req=1 at pc, pc+=4.
//   - IF/ID<={inflight_v, imem_rdata, inflight_pc}.
//   - inflight<=this request.
//  RUN, stall:
//   - imem_req=0; pc and IF/ID hold.
//   - If inflight_v: skid<={imem_rdata, inflight_pc}.
//   - inflight cleared; state<=HOLD.
//  HOLD, stall: everything holds; imem_req=0.
//  HOLD, no stall:
//   - IF/ID<=skid (valid=skid_v); skid cleared.
//   - imem_req=1 at pc, pc+=4, inflight set; state<=RUN.
//  Ordering guarantee: every fetched non-squashed instruction enters IF/ID exactly once, in program order.
//  PC arithmetic is unsigned mod 2^ADDR_W; 0xFFFF_FFFF_FFFF_FFFC+4 = 0.
//  if_id_instr=NOP_INSTR whenever if_id_valid is loaded 0.
//  fetch_count increments on each edge that loads IF/ID with valid=1.
//  Reset asserted mid-operation:
//   - All outputs go to reset values immediately, without waiting for clk.
//   - In-flight and skid data are discarded; BOOT restarts at RESET_PC.
// STRUCTURE
//  cpu_pkg holds:
//   - typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t
//   - NOP_INSTR and RESET_PC constants
//   - the INSTR_W / ADDR_W localparams shared with the decode stage
//  Sub-module fetch_skid_buf: one-entry {valid, instr, pc} hold register with load/clear.
//  Next-PC adder, state register and IF/ID register live in fetch_stage.
// TESTING
//  1. Reset low 2 cycles, then high with imem returning addr-derived data
//     -> imem_addr 0x0,0x4,0x8 on successive cycles; first if_id_valid=1 with if_id_pc=0x0 two edges after release.
//  2. Running; stall high 3 cycles while if_id_pc=0x8
//     -> IF/ID holds 0x8, imem_req=0 during stall; after release if_id_pc=0xC then 0x10, none dropped or repeated.
//  3. redirect=1, redirect_pc=0x100 while fetching 0x14
//     -> imem_addr=0x100 that cycle; next cycle if_id_valid=0 with NOP_INSTR; then if_id_pc 0x100, 0x104.
//  4. redirect and stall together in HOLD with skid full; redirect_pc=0x202
//     -> redirect wins, skid dropped, fetch from 0x200; fetch_count does not count squashed entries.
//  5. reset dropped mid-HOLD, between clock edges
//     -> outputs reset immediately; after release the fetch sequence restarts at 0x0.
//  6. redirect_pc=0xFFFF_FFFF_FFFF_FFFC
//     -> next request at 0x0; fetch_count wraps 0xFFFF_FFFF->0 when preloaded by a long run.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU front-end types and constants used by the fetch stage and the decode stage.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 64'h0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;

    // Instructions are word aligned, so the low two address bits are ignored.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the instruction-memory, decode-control and IF/ID signals around the fetch stage.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               if_id_valid;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc;
    logic [31:0]        fetch_count;

    modport master (
        output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, fetch_count,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, fetch_count,
        output imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry {valid, instr, pc} hold register; catches memory data that returns while decode stalls.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Clear wins over load so a redirect always discards the buffered entry.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory and fills IF/ID.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_stage_if.master bus
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]        fetch_count_q, fetch_count_d;
    logic               ifid_load;
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  target;
    logic               skid_load, skid_clear, skid_v;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (bus.imem_rdata),
        .pc_i    (inflight_pc_q),
        .valid_o (skid_v),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    // Redirect overrides everything; otherwise the state decides between fetching and holding.
    always_comb begin
        target        = align_pc(bus.redirect_pc);
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_v_d  = inflight_v_q;
        inflight_pc_d = inflight_pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_load     = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        req           = 1'b0;
        addr          = pc_q;

        if (bus.redirect) begin
            req           = 1'b1;
            addr          = target;
            pc_d          = target + ADDR_W'(4);
            ifid_load     = 1'b1;
            ifid_valid_d  = 1'b0;
            ifid_instr_d  = NOP_INSTR;
            inflight_v_d  = 1'b1;
            inflight_pc_d = target;
            skid_clear    = 1'b1;
            state_d       = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    if (!bus.stall) begin
                        req           = 1'b1;
                        pc_d          = pc_q + ADDR_W'(4);
                        inflight_v_d  = 1'b1;
                        inflight_pc_d = pc_q;
                        state_d       = RUN;
                    end
                end
                RUN: begin
                    if (bus.stall) begin
                        skid_load    = inflight_v_q;
                        inflight_v_d = 1'b0;
                        state_d      = HOLD;
                    end else begin
                        req           = 1'b1;
                        pc_d          = pc_q + ADDR_W'(4);
                        ifid_load     = 1'b1;
                        ifid_valid_d  = inflight_v_q;
                        ifid_instr_d  = inflight_v_q ? bus.imem_rdata : NOP_INSTR;
                        ifid_pc_d     = inflight_pc_q;
                        inflight_v_d  = 1'b1;
                        inflight_pc_d = pc_q;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        req           = 1'b1;
                        pc_d          = pc_q + ADDR_W'(4);
                        ifid_load     = 1'b1;
                        ifid_valid_d  = skid_v;
                        ifid_instr_d  = skid_v ? skid_instr : NOP_INSTR;
                        ifid_pc_d     = skid_pc;
                        skid_clear    = 1'b1;
                        inflight_v_d  = 1'b1;
                        inflight_pc_d = pc_q;
                        state_d       = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end

        fetch_count_d = fetch_count_q + 32'(ifid_load && ifid_valid_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // The request is combinational, so it is gated to stay low while reset is held.
    assign bus.imem_req    = req & rst_ni;
    assign bus.imem_addr   = addr;
    assign bus.if_id_valid = ifid_valid_q;
    assign bus.if_id_instr = ifid_instr_q;
    assign bus.if_id_pc    = ifid_pc_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a queue-based model of fetched addresses.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst_ni;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    // Synchronous-read memory: data for a request appears after the edge that accepted it.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= memWord(bus.imem_addr);
    end

    // Model: addresses requested but not yet delivered to IF/ID, in program order.
    logic [63:0] pendQ[$];
    logic [63:0] mNext;
    logic        mValid;
    logic [63:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mCount;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        pendQ.delete();
        mNext  = RESET_PC;
        mValid = 1'b0;
        mPc    = 64'h0;
        mInstr = NOP_INSTR;
        mCount = 32'h0;
    endtask

    task automatic modelEdge(input logic st, input logic rd, input logic [63:0] rpc);
        logic [63:0] tgt;
        tgt = {rpc[63:2], 2'b00};
        if (rd) begin
            pendQ.delete();
            pendQ.push_back(tgt);
            mValid = 1'b0;
            mInstr = NOP_INSTR;
            mNext  = tgt + 64'd4;
        end else if (!st) begin
            if (pendQ.size() > 0) begin
                mPc    = pendQ.pop_front();
                mValid = 1'b1;
                mInstr = memWord(mPc);
                mCount = mCount + 32'd1;
            end else begin
                mValid = 1'b0;
                mInstr = NOP_INSTR;
            end
            pendQ.push_back(mNext);
            mNext = mNext + 64'd4;
        end
    endtask

    task automatic checkOutput();
        chk("if_id_valid", 64'(bus.if_id_valid), 64'(mValid));
        if (mValid) chk("if_id_pc", bus.if_id_pc, mPc);
        chk("if_id_instr", 64'(bus.if_id_instr), 64'(mInstr));
        chk("fetch_count", 64'(bus.fetch_count), 64'(mCount));
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_req"},   64'(bus.imem_req), 64'd0);
        chk({tag, "_valid"}, 64'(bus.if_id_valid), 64'd0);
        chk({tag, "_instr"}, 64'(bus.if_id_instr), 64'(NOP_INSTR));
        chk({tag, "_pc"},    bus.if_id_pc, 64'd0);
        chk({tag, "_count"}, 64'(bus.fetch_count), 64'd0);
    endtask

    // One clock cycle: drive inputs after the falling edge, check the combinational request,
    // advance the model on the rising edge and check the registered outputs on the next falling edge.
    task automatic applyStimulus(input logic st, input logic rd, input logic [63:0] rpc);
        logic        expReq;
        logic [63:0] expAddr;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
        expReq  = rd | ~st;
        expAddr = rd ? {rpc[63:2], 2'b00} : mNext;
        chk("imem_req", 64'(bus.imem_req), 64'(expReq));
        if (expReq) chk("imem_addr", bus.imem_addr, expAddr);
        @(posedge clk);
        modelEdge(st, rd, rpc);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic        st;
        logic        rd;
        logic [63:0] rpc;
        logic [31:0] countBefore;
        checks          = 0;
        errors          = 0;
        rst_ni          = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        resetModel();

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_ni = 1'b1;

        // Boot sequence: requests 0x0, 0x4, 0x8 and first valid entry two edges after release.
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("boot_first_pc", bus.if_id_pc, 64'h0);
        chk("boot_first_valid", 64'(bus.if_id_valid), 64'd1);
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("pre_stall_pc", bus.if_id_pc, 64'h8);

        repeat (3) applyStimulus(1'b1, 1'b0, 64'h0);
        chk("stall_hold_pc", bus.if_id_pc, 64'h8);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("stall_release_pc0", bus.if_id_pc, 64'hC);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("stall_release_pc1", bus.if_id_pc, 64'h10);

        // Branch redirect squashes the wrong path.
        applyStimulus(1'b0, 1'b1, 64'h100);
        chk("redir_bubble_valid", 64'(bus.if_id_valid), 64'd0);
        chk("redir_bubble_instr", 64'(bus.if_id_instr), 64'(NOP_INSTR));
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("redir_target_pc", bus.if_id_pc, 64'h100);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("redir_next_pc", bus.if_id_pc, 64'h104);

        // Redirect and stall together while HOLD has a buffered entry.
        applyStimulus(1'b1, 1'b0, 64'h0);
        countBefore = mCount;
        applyStimulus(1'b1, 1'b1, 64'h202);
        chk("redir_hold_count", 64'(bus.fetch_count), 64'(countBefore));
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("redir_hold_pc", bus.if_id_pc, 64'h200);

        // Asynchronous reset between clock edges while in HOLD.
        applyStimulus(1'b1, 1'b0, 64'h0);
        bus.stall = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        resetModel();
        @(negedge clk);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("restart_pc", bus.if_id_pc, 64'h0);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.redirect = 1'b0;
        #1;
        chk("pc_wrap_addr", bus.imem_addr, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        chk("pc_wrap_ifid", bus.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else
                rpc = 64'($urandom_range(0, 4095));
            applyStimulus(st, rd, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
